router_rx_sink: RTL and testbench

Packet receiver attached to one output port of the 1x3 router (`data_out_N` / `valid_out_N` / `read_enb_N`). It drains the port FIFO through the read-enable handshake and reassembles each packet (header, payload, parity). It recomputes the XOR parity, streams payload bytes to the downstream consumer, and keeps packet and error statistics. One instance sits on each of the three router outputs.

---
 rtl/router_rx_sink.sv | 181 ++++++++++++++++++
 tb/tb_router_rx_sink.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_rx_sink.sv
// Packet receiver for one router output port: drains the port FIFO, reassembles
// header/payload/parity, streams payload bytes and keeps packet/error statistics.
module router_rx_sink #(
  parameter int READ_DELAY  = 0,
  parameter int GAP_TIMEOUT = 40,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid_out,
  input  logic [7:0]       data_out,
  output logic             read_enb,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             pkt_done,
  output logic [1:0]       pkt_addr,
  output logic [5:0]       pkt_len,
  output logic             parity_err,
  output logic             timeout_err,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);
  localparam logic [4:0] DLY_LOAD = (READ_DELAY > 0) ? 5'(READ_DELAY - 1) : 5'd0;

  typedef enum logic [2:0] {
    IDLE,
    DLY,
    HDR_RD,
    HDR_CAP,
    BODY,
    DONE
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             rd_q;
  logic             rd_allow;
  logic [4:0]       dly_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       acc;
  logic [6:0]       remain;
  logic [6:0]       req;
  logic             body_cap;
  logic             gap_hit;

  // req counts reads still to issue, so the parity byte is the last one ever requested
  assign rd_allow = (state == HDR_RD) || ((state == BODY) && (req != 7'd0));
  assign read_enb = rd_allow & valid_out;
  assign body_cap = (state == BODY) && rd_q;
  assign gap_hit  = !rd_q && (gap_cnt == GAP_LAST) &&
                    ((state == HDR_CAP) || (state == BODY));

  always_comb begin
    next_state = state;
    out_valid  = 1'b0;
    out_data   = 8'd0;
    pkt_done   = 1'b0;
    case (state)
      IDLE: begin
        if (valid_out) begin
          next_state = (READ_DELAY == 0) ? HDR_RD : DLY;
        end
      end
      DLY: begin
        if (dly_cnt == 5'd0) begin
          next_state = HDR_RD;
        end
      end
      HDR_RD: begin
        if (valid_out) begin
          next_state = HDR_CAP;
        end
      end
      HDR_CAP: begin
        if (rd_q) begin
          next_state = BODY;
        end else if (gap_hit) begin
          next_state = DONE;
        end
      end
      BODY: begin
        if (body_cap && (remain > 7'd1)) begin
          out_valid = 1'b1;
          out_data  = data_out;
        end
        if ((body_cap && (remain == 7'd1)) || gap_hit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        pkt_done   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      rd_q        <= 1'b0;
      dly_cnt     <= 5'd0;
      gap_cnt     <= '0;
      acc         <= 8'd0;
      remain      <= 7'd0;
      req         <= 7'd0;
      pkt_addr    <= 2'd0;
      pkt_len     <= 6'd0;
      parity_err  <= 1'b0;
      timeout_err <= 1'b0;
      pkt_count   <= '0;
      err_count   <= '0;
    end else begin
      state <= next_state;
      rd_q  <= read_enb;
      case (state)
        IDLE: begin
          dly_cnt <= DLY_LOAD;
        end
        DLY: begin
          if (dly_cnt != 5'd0) begin
            dly_cnt <= dly_cnt - 5'd1;
          end
        end
        HDR_RD: begin
          gap_cnt <= '0;
        end
        HDR_CAP: begin
          if (rd_q) begin
            pkt_addr <= data_out[1:0];
            pkt_len  <= data_out[7:2];
            acc      <= data_out;
            remain   <= {1'b0, data_out[7:2]} + 7'd1;
            req      <= {1'b0, data_out[7:2]} + 7'd1;
            gap_cnt  <= '0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
            if (gap_hit) begin
              timeout_err <= 1'b1;
              parity_err  <= 1'b0;
            end
          end
        end
        BODY: begin
          if (read_enb) begin
            req <= req - 7'd1;
          end
          if (rd_q) begin
            acc     <= acc ^ data_out;
            remain  <= remain - 7'd1;
            gap_cnt <= '0;
            // acc still excludes this byte, so equality means the parity matched
            if (remain == 7'd1) begin
              parity_err  <= (acc != data_out);
              timeout_err <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
            if (gap_hit) begin
              timeout_err <= 1'b1;
              parity_err  <= 1'b0;
            end
          end
        end
        DONE: begin
          if (!(&pkt_count)) begin
            pkt_count <= pkt_count + CNT_W'(1);
          end
          if ((parity_err || timeout_err) && !(&err_count)) begin
            err_count <= err_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_router_rx_sink.sv
// Directed bench for router_rx_sink: two instances (READ_DELAY 0 and 10), each fed
// by a small model of the router port FIFO with a one-cycle registered read.
module tb_router_rx_sink;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    int len;
    int addr;
    bit corrupt;
    int exp_out;
    bit exp_perr;
    int exp_pc;
    int exp_ec;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // instance a: READ_DELAY = 0
  logic        valid_a = 1'b0;
  logic [7:0]  data_a = 8'd0;
  logic        rd_a, ov_a, done_a, perr_a, terr_a;
  logic [7:0]  od_a;
  logic [1:0]  addr_a;
  logic [5:0]  len_a;
  logic [15:0] pc_a, ec_a;

  // instance b: READ_DELAY = 10
  logic        valid_b = 1'b0;
  logic [7:0]  data_b = 8'd0;
  logic        rd_b, ov_b, done_b, perr_b, terr_b;
  logic [7:0]  od_b;
  logic [1:0]  addr_b;
  logic [5:0]  len_b;
  logic [15:0] pc_b, ec_b;

  router_rx_sink #(.READ_DELAY(0), .GAP_TIMEOUT(40), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .valid_out(valid_a), .data_out(data_a),
    .read_enb(rd_a), .out_data(od_a), .out_valid(ov_a), .pkt_done(done_a),
    .pkt_addr(addr_a), .pkt_len(len_a), .parity_err(perr_a), .timeout_err(terr_a),
    .pkt_count(pc_a), .err_count(ec_a)
  );

  router_rx_sink #(.READ_DELAY(10), .GAP_TIMEOUT(40), .CNT_W(16)) dut_dly (
    .clock(clock), .reset(reset), .valid_out(valid_b), .data_out(data_b),
    .read_enb(rd_b), .out_data(od_b), .out_valid(ov_b), .pkt_done(done_b),
    .pkt_addr(addr_b), .pkt_len(len_b), .parity_err(perr_b), .timeout_err(terr_b),
    .pkt_count(pc_b), .err_count(ec_b)
  );

  // Port FIFO models: data appears the cycle after the read, valid follows occupancy
  logic [7:0] fifo_a[$];
  logic [7:0] fifo_b[$];
  always @(posedge clock) begin
    if (rd_a && fifo_a.size() != 0) data_a <= fifo_a.pop_front();
    valid_a <= (fifo_a.size() != 0);
    if (rd_b && fifo_b.size() != 0) data_b <= fifo_b.pop_front();
    valid_b <= (fifo_b.size() != 0);
  end

  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  int ov_cnt_a, rd_cnt_a, done_cnt_a, bad_a, done_cyc_a, first_valid_a, first_rd_a, last_ov_a;
  int ov_cnt_b, done_cnt_b, bad_b, done_cyc_b, first_valid_b, first_rd_b;

  always @(negedge clock) begin
    if (ov_a) begin
      ov_cnt_a++;
      last_ov_a = cyc;
      if (exp_q_a.size() == 0) bad_a++;
      else if (exp_q_a.pop_front() != od_a) bad_a++;
    end
    if (rd_a) rd_cnt_a++;
    if (rd_a && first_rd_a < 0) first_rd_a = cyc;
    if (valid_a && first_valid_a < 0) first_valid_a = cyc;
    if (done_a) begin
      done_cnt_a++;
      done_cyc_a = cyc;
    end
    if (ov_b) begin
      ov_cnt_b++;
      if (exp_q_b.size() == 0) bad_b++;
      else if (exp_q_b.pop_front() != od_b) bad_b++;
    end
    if (rd_b && first_rd_b < 0) first_rd_b = cyc;
    if (valid_b && first_valid_b < 0) first_valid_b = cyc;
    if (done_b) begin
      done_cnt_b++;
      done_cyc_b = cyc;
    end
  end

  task automatic clear_mon();
    ov_cnt_a = 0; rd_cnt_a = 0; done_cnt_a = 0; bad_a = 0;
    done_cyc_a = -1; first_valid_a = -1; first_rd_a = -1; last_ov_a = -1;
    ov_cnt_b = 0; done_cnt_b = 0; bad_b = 0;
    done_cyc_b = -1; first_valid_b = -1; first_rd_b = -1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic byte_q_t make_packet(input int len, input int addr, input int seed,
                                          input bit corrupt);
    byte_q_t p;
    logic [7:0] b;
    logic [7:0] par;
    b = {6'(len), 2'(addr)};
    p.push_back(b);
    par = b;
    for (int i = 0; i < len; i++) begin
      b = 8'(8'h30 + 17 * i + 5 * seed);
      p.push_back(b);
      par = par ^ b;
    end
    p.push_back(corrupt ? ~par : par);
    return p;
  endfunction

  task automatic wait_done_a(input int budget);
    for (int i = 0; i < budget && done_cnt_a == 0; i++) @(posedge clock);
    repeat (3) @(posedge clock);
    #1;
  endtask

  // Loads one packet into FIFO a and waits (bounded) for it to finish
  task automatic applyStimulus(input vec_t v, input int seed);
    byte_q_t pkt;
    clear_mon();
    pkt = make_packet(v.len, v.addr, seed, v.corrupt);
    for (int i = 0; i < pkt.size(); i++) fifo_a.push_back(pkt[i]);
    for (int i = 1; i <= v.len; i++) exp_q_a.push_back(pkt[i]);
    wait_done_a(v.len + 40);
  endtask

  task automatic check_vector(input string tag, input vec_t v);
    checkOutput({tag, "_done_pulses"}, done_cnt_a, 1);
    checkOutput({tag, "_out_valid_count"}, ov_cnt_a, v.exp_out);
    checkOutput({tag, "_payload_order_errs"}, bad_a + exp_q_a.size(), 0);
    checkOutput({tag, "_pkt_len"}, 32'(len_a), v.len);
    checkOutput({tag, "_pkt_addr"}, 32'(addr_a), v.addr);
    checkOutput({tag, "_parity_err"}, 32'(perr_a), 32'(v.exp_perr));
    checkOutput({tag, "_timeout_err"}, 32'(terr_a), 0);
    checkOutput({tag, "_pkt_count"}, 32'(pc_a), v.exp_pc);
    checkOutput({tag, "_err_count"}, 32'(ec_a), v.exp_ec);
    checkOutput({tag, "_reads_issued"}, rd_cnt_a, v.len + 2);
    checkOutput({tag, "_first_read_lat"}, first_rd_a - first_valid_a, 1);
    // valid high in cycle 0 puts pkt_done in cycle L+5, the (L+6)th cycle
    checkOutput({tag, "_done_latency"}, done_cyc_a - first_valid_a, v.len + 5);
    checkOutput({tag, "_read_enb_idle"}, 32'(rd_a), 0);
  endtask

  task automatic check_zero(input string tag);
    checkOutput({tag, "_read_enb"}, 32'(rd_a), 0);
    checkOutput({tag, "_out_data"}, 32'(od_a), 0);
    checkOutput({tag, "_out_valid"}, 32'(ov_a), 0);
    checkOutput({tag, "_pkt_done"}, 32'(done_a), 0);
    checkOutput({tag, "_addr_len"}, {24'd0, len_a, addr_a}, 0);
    checkOutput({tag, "_err_flags"}, {30'd0, perr_a, terr_a}, 0);
    checkOutput({tag, "_counters"}, {pc_a, ec_a}, 0);
  endtask

  vec_t vecs[5];
  vec_t v;
  byte_q_t pkt;

  initial begin
    vecs[0] = '{len: 8,  addr: 1, corrupt: 1'b0, exp_out: 8,  exp_perr: 1'b0, exp_pc: 1, exp_ec: 0};
    vecs[1] = '{len: 14, addr: 2, corrupt: 1'b1, exp_out: 14, exp_perr: 1'b1, exp_pc: 2, exp_ec: 1};
    vecs[2] = '{len: 0,  addr: 2, corrupt: 1'b0, exp_out: 0,  exp_perr: 1'b0, exp_pc: 3, exp_ec: 1};
    vecs[3] = '{len: 63, addr: 0, corrupt: 1'b0, exp_out: 63, exp_perr: 1'b0, exp_pc: 4, exp_ec: 1};
    vecs[4] = '{len: 1,  addr: 3, corrupt: 1'b1, exp_out: 1,  exp_perr: 1'b1, exp_pc: 5, exp_ec: 2};
    clear_mon();

    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    checkOutput("reset_b_outputs", {rd_b, ov_b, done_b, perr_b, terr_b, od_b}, 0);
    checkOutput("reset_b_counters", {pc_b, ec_b}, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    $display("[TB] table vectors");
    for (int n = 0; n < 5; n++) begin
      applyStimulus(vecs[n], n);
      check_vector($sformatf("v%0d", n), vecs[n]);
    end

    $display("[TB] gap timeout: header plus 5 of 14 payload bytes");
    clear_mon();
    pkt = make_packet(14, 1, 9, 1'b0);
    for (int i = 0; i < 6; i++) fifo_a.push_back(pkt[i]);
    for (int i = 1; i <= 5; i++) exp_q_a.push_back(pkt[i]);
    wait_done_a(120);
    checkOutput("gap_done_pulses", done_cnt_a, 1);
    checkOutput("gap_out_valid_count", ov_cnt_a, 5);
    checkOutput("gap_payload_order_errs", bad_a + exp_q_a.size(), 0);
    checkOutput("gap_timeout_err", 32'(terr_a), 1);
    checkOutput("gap_parity_err", 32'(perr_a), 0);
    checkOutput("gap_pkt_len", 32'(len_a), 14);
    checkOutput("gap_pkt_count", 32'(pc_a), 6);
    checkOutput("gap_err_count", 32'(ec_a), 3);
    checkOutput("gap_wait_in_range",
                32'((done_cyc_a - last_ov_a >= 40) && (done_cyc_a - last_ov_a <= 45)), 1);
    checkOutput("gap_read_enb_idle", 32'(rd_a), 0);

    $display("[TB] read delay 10 on second instance");
    clear_mon();
    pkt = make_packet(4, 1, 3, 1'b0);
    for (int i = 0; i < pkt.size(); i++) fifo_b.push_back(pkt[i]);
    for (int i = 1; i <= 4; i++) exp_q_b.push_back(pkt[i]);
    for (int i = 0; i < 80 && done_cnt_b == 0; i++) @(posedge clock);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("dly_first_read_lat", first_rd_b - first_valid_b, 11);
    checkOutput("dly_done_latency", done_cyc_b - first_valid_b, 4 + 5 + 10);
    checkOutput("dly_done_pulses", done_cnt_b, 1);
    checkOutput("dly_out_valid_count", ov_cnt_b, 4);
    checkOutput("dly_payload_order_errs", bad_b + exp_q_b.size(), 0);
    checkOutput("dly_flags", {30'd0, perr_b, terr_b}, 0);
    checkOutput("dly_pkt_len_addr", {24'd0, len_b, addr_b}, {24'd0, 6'd4, 2'd1});
    checkOutput("dly_counters", {pc_b, ec_b}, {16'd1, 16'd0});

    $display("[TB] reset mid-payload");
    clear_mon();
    pkt = make_packet(20, 1, 7, 1'b0);
    for (int i = 0; i < pkt.size(); i++) fifo_a.push_back(pkt[i]);
    for (int i = 1; i <= 20; i++) exp_q_a.push_back(pkt[i]);
    for (int i = 0; i < 100 && ov_cnt_a < 6; i++) @(posedge clock);
    #1;
    checkOutput("mid_reached_payload", 32'(ov_cnt_a >= 6), 1);
    reset = 1'b1;
    fifo_a.delete();
    @(posedge clock);
    #1;
    check_zero("mid_reset");
    reset = 1'b0;
    exp_q_a.delete();
    repeat (5) @(posedge clock);
    #1;
    checkOutput("mid_no_done", done_cnt_a, 0);
    v = '{len: 3, addr: 2, corrupt: 1'b0, exp_out: 3, exp_perr: 1'b0, exp_pc: 1, exp_ec: 0};
    applyStimulus(v, 11);
    check_vector("post_reset", v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
